fifo_write_arbiter: RTL and testbench

- Shares the single FIFO write port (WR_EN / data-in, gated by Full) between two independent producers.
- Arbitrates with round-robin priority and grants in bursts of up to BURST_LEN words.
- Drives WR_EN / DATA_OUT directly into the FIFO write-pointer / memory path.
- Returns a per-requester ACK so each producer knows when its word was written.

---
 rtl/fifo_write_arbiter_if.sv | 26 ++
 rtl/fifo_write_arbiter.sv | 125 ++++++++++++
 tb/tb_fifo_write_arbiter.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/fifo_write_arbiter_if.sv
// Producer-side bundle for the shared FIFO write port: two request/data/ack
// channels in, one write enable and data word out to the FIFO.
interface fifo_write_arbiter_if #(
  parameter int DATA_W = 8
);
  logic              REQ0;
  logic [DATA_W-1:0] DATA0;
  logic              ACK0;
  logic              REQ1;
  logic [DATA_W-1:0] DATA1;
  logic              ACK1;
  logic              Full;
  logic              WR_EN;
  logic [DATA_W-1:0] DATA_OUT;
  logic [1:0]        GNT;

  modport slave (
    input  REQ0, DATA0, REQ1, DATA1, Full,
    output ACK0, ACK1, WR_EN, DATA_OUT, GNT
  );

  modport master (
    output REQ0, DATA0, REQ1, DATA1, Full,
    input  ACK0, ACK1, WR_EN, DATA_OUT, GNT
  );
endinterface

// File: rtl/fifo_write_arbiter.sv
// Round-robin arbiter sharing one FIFO write port between two producers,
// granting bursts of up to BURST_LEN accepted words per grant.
module fifo_write_arbiter #(
  parameter int DATA_W    = 8,
  parameter int BURST_LEN = 4
) (
  input  logic                  CLK,
  input  logic                  RST,
  fifo_write_arbiter_if.slave   bus
);

  localparam int CNT_W = $clog2(BURST_LEN + 1);
  localparam logic [CNT_W-1:0] BURST_LAST = CNT_W'(BURST_LEN - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    G0   = 2'd1,
    G1   = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic             last_q,  last_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;

  logic              req_own;
  logic              req_oth;
  logic              own_idx;
  state_e            oth_state;
  logic              wr_en;
  logic [1:0]        gnt;
  logic [DATA_W-1:0] data_out;

  // NOTE: every variable is given a default before the case statement, so no
  // path through this block can leave one unassigned and infer a latch.
  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    cnt_d     = cnt_q;
    gnt       = 2'b00;
    req_own   = 1'b0;
    req_oth   = 1'b0;
    own_idx   = 1'b0;
    oth_state = IDLE;
    data_out  = '0;

    case (state_q)
      G0: begin
        gnt       = 2'b01;
        req_own   = bus.REQ0;
        req_oth   = bus.REQ1;
        own_idx   = 1'b0;
        oth_state = G1;
        data_out  = bus.DATA0;
      end
      G1: begin
        gnt       = 2'b10;
        req_own   = bus.REQ1;
        req_oth   = bus.REQ0;
        own_idx   = 1'b1;
        oth_state = G0;
        data_out  = bus.DATA1;
      end
      default: ;
    endcase

    wr_en = req_own & ~bus.Full;

    if (state_q == IDLE) begin
      // LAST=1 means port 0 wins a tie, LAST=0 means port 1 does.
      if (bus.REQ0 && bus.REQ1) begin
        state_d = last_q ? G0 : G1;
        last_d  = ~last_q;
        cnt_d   = '0;
      end else if (bus.REQ0) begin
        state_d = G0;
        last_d  = 1'b0;
        cnt_d   = '0;
      end else if (bus.REQ1) begin
        state_d = G1;
        last_d  = 1'b1;
        cnt_d   = '0;
      end
    end else if (!req_own) begin
      // Owner withdrew; also the recovery path out of the unused encoding.
      if (req_oth) begin
        state_d = oth_state;
        last_d  = ~own_idx;
        cnt_d   = '0;
      end else begin
        state_d = IDLE;
      end
    end else if (wr_en) begin
      if (cnt_q == BURST_LAST) begin
        cnt_d = '0;
        if (req_oth) begin
          state_d = oth_state;
          last_d  = ~own_idx;
        end
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values computed above, independent of statement order.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.GNT      = gnt;
  assign bus.WR_EN    = wr_en;
  assign bus.ACK0     = wr_en & (state_q == G0);
  assign bus.ACK1     = wr_en & (state_q == G1);
  assign bus.DATA_OUT = data_out;

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Directed bench for fifo_write_arbiter: a vector table for single-cycle
// expectations plus hand-built sequences for bursts, alternation and reset.
module tb_fifo_write_arbiter;

  localparam int DATA_W    = 8;
  localparam int BURST_LEN = 4;

  logic CLK;
  logic RST;

  fifo_write_arbiter_if #(.DATA_W(DATA_W)) bus ();

  fifo_write_arbiter #(
    .DATA_W    (DATA_W),
    .BURST_LEN (BURST_LEN)
  ) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct packed {
    logic       rst_n;
    logic       req0;
    logic [7:0] d0;
    logic       req1;
    logic [7:0] d1;
    logic       full;
    logic [1:0] gnt;
    logic       wr;
    logic       a0;
    logic       a1;
    logic [7:0] dout;
  } vec_t;

  int n_checks = 0;
  int n_pass   = 0;
  int step_no  = 0;

  function automatic vec_t mk(logic rst_n, logic req0, logic [7:0] d0,
                              logic req1, logic [7:0] d1, logic full,
                              logic [1:0] gnt, logic wr, logic a0, logic a1,
                              logic [7:0] dout);
    vec_t v;
    v.rst_n = rst_n; v.req0 = req0; v.d0 = d0; v.req1 = req1; v.d1 = d1;
    v.full  = full;  v.gnt  = gnt;  v.wr = wr; v.a0   = a0;   v.a1 = a1;
    v.dout  = dout;
    return v;
  endfunction

  task automatic check(input string name, input logic [12:0] actual,
                       input logic [12:0] expected);
    n_checks++;
    if (actual === expected) n_pass++;
    else $display("FAIL %s step %0d: got {gnt,wr,ack0,ack1,dout}=%h expected %h",
                  name, step_no, actual, expected);
  endtask

  // Drive inputs just after a rising edge, compare at the falling edge,
  // then return aligned to the next rising edge.
  task automatic apply(input string name, input vec_t v);
    #1;
    RST       = v.rst_n;
    bus.REQ0  = v.req0;
    bus.DATA0 = v.d0;
    bus.REQ1  = v.req1;
    bus.DATA1 = v.d1;
    bus.Full  = v.full;
    @(negedge CLK);
    check(name, {bus.GNT, bus.WR_EN, bus.ACK0, bus.ACK1, bus.DATA_OUT},
                {v.gnt, v.wr, v.a0, v.a1, v.dout});
    step_no++;
    @(posedge CLK);
  endtask

  vec_t tbl [20];

  initial begin
    int n0, n1;
    RST       = 1'b0;
    bus.REQ0  = 1'b0;
    bus.DATA0 = '0;
    bus.REQ1  = 1'b0;
    bus.DATA1 = '0;
    bus.Full  = 1'b0;

    //            rst req0 d0     req1 d1     full gnt    wr a0 a1 dout
    tbl[0]  = mk(0, 1, 8'hA5, 0, 8'h00, 0, 2'b00, 0, 0, 0, 8'h00);
    tbl[1]  = mk(1, 1, 8'hA5, 0, 8'h00, 0, 2'b00, 0, 0, 0, 8'h00);
    tbl[2]  = mk(1, 1, 8'hA5, 0, 8'h00, 0, 2'b01, 1, 1, 0, 8'hA5);
    tbl[3]  = mk(1, 0, 8'h00, 0, 8'h00, 0, 2'b01, 0, 0, 0, 8'h00);
    tbl[4]  = mk(1, 1, 8'h10, 0, 8'h00, 0, 2'b00, 0, 0, 0, 8'h00);
    tbl[5]  = mk(1, 1, 8'h10, 1, 8'hB0, 0, 2'b01, 1, 1, 0, 8'h10);
    tbl[6]  = mk(1, 1, 8'h11, 1, 8'hB0, 0, 2'b01, 1, 1, 0, 8'h11);
    tbl[7]  = mk(1, 1, 8'h12, 1, 8'hB0, 1, 2'b01, 0, 0, 0, 8'h12);
    tbl[8]  = mk(1, 1, 8'h12, 1, 8'hB0, 1, 2'b01, 0, 0, 0, 8'h12);
    tbl[9]  = mk(1, 1, 8'h12, 1, 8'hB0, 1, 2'b01, 0, 0, 0, 8'h12);
    tbl[10] = mk(1, 1, 8'h12, 1, 8'hB0, 0, 2'b01, 1, 1, 0, 8'h12);
    tbl[11] = mk(1, 1, 8'h13, 1, 8'hB0, 0, 2'b01, 1, 1, 0, 8'h13);
    tbl[12] = mk(1, 0, 8'h00, 1, 8'hB0, 0, 2'b10, 1, 0, 1, 8'hB0);
    tbl[13] = mk(1, 1, 8'h20, 0, 8'hB0, 0, 2'b10, 0, 0, 0, 8'hB0);
    tbl[14] = mk(1, 1, 8'h20, 0, 8'h00, 0, 2'b01, 1, 1, 0, 8'h20);
    tbl[15] = mk(1, 0, 8'h00, 0, 8'h00, 0, 2'b01, 0, 0, 0, 8'h00);
    tbl[16] = mk(1, 1, 8'h30, 1, 8'h31, 0, 2'b00, 0, 0, 0, 8'h00);
    tbl[17] = mk(1, 1, 8'h30, 1, 8'h31, 0, 2'b10, 1, 0, 1, 8'h31);
    tbl[18] = mk(1, 0, 8'h00, 0, 8'h00, 0, 2'b10, 0, 0, 0, 8'h00);
    tbl[19] = mk(1, 0, 8'h00, 0, 8'h00, 0, 2'b00, 0, 0, 0, 8'h00);

    repeat (2) @(posedge CLK);

    for (int i = 0; i < 20; i++) apply("table", tbl[i]);

    // Both producers saturating: expect 4xP0, 4xP1, 4xP0 with no gap.
    n0 = 0;
    n1 = 0;
    apply("alt_arb", mk(1, 1, 8'h40, 1, 8'h80, 0, 2'b00, 0, 0, 0, 8'h00));
    for (int k = 0; k < 12; k++) begin
      logic [7:0] d0, d1;
      d0 = 8'(8'h40 + n0);
      d1 = 8'(8'h80 + n1);
      if (((k / BURST_LEN) % 2) == 0) begin
        apply("alt_p0", mk(1, 1, d0, 1, d1, 0, 2'b01, 1, 1, 0, d0));
        n0++;
      end else begin
        apply("alt_p1", mk(1, 1, d0, 1, d1, 0, 2'b10, 1, 0, 1, d1));
        n1++;
      end
    end
    apply("alt_drop", mk(1, 0, 8'h00, 0, 8'h00, 0, 2'b10, 0, 0, 0, 8'h00));
    apply("alt_idle", mk(1, 0, 8'h00, 0, 8'h00, 0, 2'b00, 0, 0, 0, 8'h00));

    // P0 alone for 10 words: grant held across burst boundaries.
    apply("solo_arb", mk(1, 1, 8'hC0, 0, 8'h00, 0, 2'b00, 0, 0, 0, 8'h00));
    for (int k = 0; k < 10; k++) begin
      logic [7:0] d;
      d = 8'(8'hC0 + k);
      apply("solo_p0", mk(1, 1, d, 0, 8'h00, 0, 2'b01, 1, 1, 0, d));
    end
    apply("solo_drop", mk(1, 0, 8'h00, 0, 8'h00, 0, 2'b01, 0, 0, 0, 8'h00));
    apply("solo_idle", mk(1, 0, 8'h00, 0, 8'h00, 0, 2'b00, 0, 0, 0, 8'h00));

    // Reset two words into a P1 burst; P0 must win the first tie afterwards.
    apply("rst_arb",  mk(1, 0, 8'h00, 1, 8'hE0, 0, 2'b00, 0, 0, 0, 8'h00));
    apply("rst_p1",   mk(1, 0, 8'h00, 1, 8'hE0, 0, 2'b10, 1, 0, 1, 8'hE0));
    apply("rst_p1",   mk(1, 0, 8'h00, 1, 8'hE1, 0, 2'b10, 1, 0, 1, 8'hE1));
    apply("rst_low",  mk(0, 0, 8'h00, 1, 8'hE2, 0, 2'b00, 0, 0, 0, 8'h00));
    apply("rst_rel",  mk(1, 1, 8'hF0, 1, 8'hE2, 0, 2'b00, 0, 0, 0, 8'h00));
    apply("rst_p0",   mk(1, 1, 8'hF0, 1, 8'hE2, 0, 2'b01, 1, 1, 0, 8'hF0));
    apply("rst_drop", mk(1, 0, 8'h00, 0, 8'h00, 0, 2'b01, 0, 0, 0, 8'h00));
    apply("rst_idle", mk(1, 0, 8'h00, 0, 8'h00, 0, 2'b00, 0, 0, 0, 8'h00));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
